mem_stage_unit: RTL and testbench

- Memory stage of the 5-stage MIPS pipeline.
- Consumes the EX/MEM register outputs (regWriteM, memToRegM, memWriteM, aluOutM, writeDataM, writeRegM).
- Drives a variable-latency data-memory bus (req/gnt/rvalid) and raises stallM to the hazard unit while an access is outstanding.
- Contains the MEM/WB pipeline register. Detects misaligned word accesses and bus timeouts.

---
 rtl/mem_pkg.sv | 27 ++
 rtl/reg_writeback.sv | 21 ++
 rtl/mem_stage_unit.sv | 146 ++++++++++++++
 tb/tb_mem_stage_unit.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the MIPS memory stage: FSM encoding, error codes and
// the MEM/WB register payload.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GNT = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } mem_state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_ALIGN   = 2'b01,
        ERR_TIMEOUT = 2'b10
    } mem_err_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic [31:0] read_data;
        logic [31:0] alu_out;
        logic [4:0]  write_reg;
        logic [1:0]  err;
    } memwb_t;

endpackage

// File: rtl/reg_writeback.sv
// MEM/WB pipeline register: loads when enabled, holds otherwise (no bubble
// insertion), clears asynchronously on reset.
module reg_writeback
    import mem_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  memwb_t wb_d,
    output memwb_t wb_q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_q <= '0;
        end else if (en) begin
            wb_q <= wb_d;
        end
    end

endmodule

// File: rtl/mem_stage_unit.sv
// Memory stage of the 5-stage MIPS pipeline: variable-latency data bus
// handshake, stall generation, alignment/timeout detection, MEM/WB register.
module mem_stage_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        regWriteM,
    input  logic        memToRegM,
    input  logic        memWriteM,
    input  logic [31:0] aluOutM,
    input  logic [31:0] writeDataM,
    input  logic [4:0]  writeRegM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        stallM,
    output logic        regWriteW,
    output logic        memToRegW,
    output logic [31:0] readDataW,
    output logic [31:0] aluOutW,
    output logic [4:0]  writeRegW,
    output logic [1:0]  errW
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [31:0]      rdata_q, rdata_d;
    mem_err_e         err_q, err_d;
    memwb_t           wb_d, wb_q;

    logic mem_op, aligned, issue, timed_out;

    assign mem_op    = memToRegM | memWriteM;
    assign aligned   = (aluOutM[1:0] == 2'b00);
    assign issue     = (state_q == IDLE) && mem_op && aligned;
    assign timed_out = (cnt_q == CNT_MAX);
    // Saturate so a grant on the final allowed cycle still times out in WAIT_RSP.
    assign cnt_inc   = timed_out ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d = dmem_gnt ? WAIT_RSP : WAIT_GNT;
                    cnt_d   = CNT_W'(1);
                    rdata_d = '0;
                    err_d   = ERR_NONE;
                end
            end
            WAIT_GNT: begin
                cnt_d = cnt_inc;
                if (dmem_gnt) begin
                    state_d = WAIT_RSP;
                end else if (timed_out) begin
                    state_d = DONE;
                    err_d   = ERR_TIMEOUT;
                end
            end
            WAIT_RSP: begin
                cnt_d = cnt_inc;
                if (dmem_rvalid) begin
                    state_d = DONE;
                    rdata_d = memToRegM ? dmem_rdata : '0;
                end else if (timed_out) begin
                    state_d = DONE;
                    err_d   = ERR_TIMEOUT;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Gated by rst so request and stall drop the instant reset asserts.
    always_comb begin
        dmem_req   = rst && (issue || (state_q == WAIT_GNT));
        stallM     = rst && (issue || (state_q == WAIT_GNT) || (state_q == WAIT_RSP));
        dmem_we    = memWriteM;
        dmem_addr  = aluOutM;
        dmem_wdata = writeDataM;
    end

    always_comb begin
        wb_d.mem_to_reg = memToRegM;
        wb_d.alu_out    = aluOutM;
        wb_d.write_reg  = writeRegM;
        wb_d.read_data  = '0;
        wb_d.err        = ERR_NONE;
        wb_d.reg_write  = regWriteM;
        if (state_q == DONE) begin
            wb_d.read_data = rdata_q;
            wb_d.err       = err_q;
            wb_d.reg_write = regWriteM && (err_q == ERR_NONE);
        end else if (mem_op && !aligned) begin
            wb_d.err       = ERR_ALIGN;
            wb_d.reg_write = 1'b0;
        end
    end

    reg_writeback u_reg_writeback (
        .clk  (clk),
        .rst  (rst),
        .en   (!stallM),
        .wb_d (wb_d),
        .wb_q (wb_q)
    );

    assign regWriteW = wb_q.reg_write;
    assign memToRegW = wb_q.mem_to_reg;
    assign readDataW = wb_q.read_data;
    assign aluOutW   = wb_q.alu_out;
    assign writeRegW = wb_q.write_reg;
    assign errW      = wb_q.err;

endmodule

// File: tb/tb_mem_stage_unit.sv
// Scoreboard bench for mem_stage_unit: each instruction pushes its expected
// MEM/WB contents, popped and compared once the stage releases it.
module tb_mem_stage_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        regWriteM = 1'b0, memToRegM = 1'b0, memWriteM = 1'b0;
    logic [31:0] aluOutM = '0, writeDataM = '0;
    logic [4:0]  writeRegM = '0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        stallM, regWriteW, memToRegW;
    logic [31:0] readDataW, aluOutW;
    logic [4:0]  writeRegW;
    logic [1:0]  errW;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rw;
        logic        m2r;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic [1:0]  err;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    mem_stage_unit #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .regWriteM(regWriteM), .memToRegM(memToRegM), .memWriteM(memWriteM),
        .aluOutM(aluOutM), .writeDataM(writeDataM), .writeRegM(writeRegM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .stallM(stallM),
        .regWriteW(regWriteW), .memToRegW(memToRegW), .readDataW(readDataW),
        .aluOutW(aluOutW), .writeRegW(writeRegW), .errW(errW)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic check_w_zero(input string tag);
        check($sformatf("%s.regWriteW", tag), 32'(regWriteW), 0);
        check($sformatf("%s.memToRegW", tag), 32'(memToRegW), 0);
        check($sformatf("%s.readDataW", tag), readDataW, 0);
        check($sformatf("%s.aluOutW", tag), aluOutW, 0);
        check($sformatf("%s.writeRegW", tag), 32'(writeRegW), 0);
        check($sformatf("%s.errW", tag), 32'(errW), 0);
        check($sformatf("%s.dmem_req", tag), 32'(dmem_req), 0);
        check($sformatf("%s.stallM", tag), 32'(stallM), 0);
    endtask

    // Called at posedge+1. gnt_dly: request cycles seen before granting
    // (<0 never); rsp_dly: cycles after the grant cycle until rvalid (<=0 never).
    task automatic run_op(input string tag, input logic rw, input logic m2r, input logic mw,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] wr,
                          input int gnt_dly, input int rsp_dly, input logic [31:0] rdata,
                          input bit stray_rv, input int exp_stall, input int exp_req,
                          input logic [31:0] exp_rd, input logic [1:0] exp_err);
        exp_t e, got;
        int req_cnt = 0, stall_cnt = 0, since = 0, cyc = 0, unstable = 0;
        bit granted = 0, done = 0, gave;
        regWriteM = rw; memToRegM = m2r; memWriteM = mw;
        aluOutM = addr; writeDataM = wdata; writeRegM = wr; dmem_rdata = rdata;
        e.rw = rw && (exp_err == 2'b00); e.m2r = m2r; e.rd = exp_rd;
        e.alu = addr; e.wr = wr; e.err = exp_err;
        sb.push_back(e);
        while (!done && cyc < 64) begin
            #1;
            gave = dmem_req && !granted && (req_cnt == gnt_dly);
            dmem_gnt = gave;
            dmem_rvalid = stray_rv || (granted && rsp_dly > 0 && since == rsp_dly);
            #1;
            if (dmem_req) begin
                req_cnt++;
                if (dmem_addr !== addr || dmem_wdata !== wdata || dmem_we !== mw) unstable++;
            end
            if (stallM) stall_cnt++;
            else done = 1;
            @(posedge clk);
            cyc++;
            if (gave) begin
                granted = 1;
                since = 1;
            end else if (granted) begin
                since++;
            end
        end
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b0;
        if (!done) check($sformatf("%s.cycle_bound", tag), 1, 0);
        #1;
        check($sformatf("%s.stall_cycles", tag), stall_cnt, exp_stall);
        check($sformatf("%s.req_cycles", tag), req_cnt, exp_req);
        check($sformatf("%s.bus_stable", tag), unstable, 0);
        got = sb.pop_front();
        check($sformatf("%s.regWriteW", tag), 32'(regWriteW), 32'(got.rw));
        check($sformatf("%s.memToRegW", tag), 32'(memToRegW), 32'(got.m2r));
        check($sformatf("%s.readDataW", tag), readDataW, got.rd);
        check($sformatf("%s.aluOutW", tag), aluOutW, got.alu);
        check($sformatf("%s.writeRegW", tag), 32'(writeRegW), 32'(got.wr));
        check($sformatf("%s.errW", tag), 32'(errW), 32'(got.err));
        $display("op %s: stall=%0d req=%0d readDataW=%h errW=%b", tag, stall_cnt, req_cnt, readDataW, errW);
    endtask

    initial begin
        // Aligned load presented during reset: request/stall must stay low.
        regWriteM = 1'b1; memToRegM = 1'b1; aluOutM = 32'h40; writeRegM = 5'd3;
        #3;
        check_w_zero("reset_start");
        @(posedge clk); @(posedge clk); #1;
        check_w_zero("reset_hold");
        regWriteM = 1'b0; memToRegM = 1'b0; aluOutM = '0; writeRegM = '0;
        rst = 1'b1;

        //      tag          rw m2r mw addr          wdata         wr   gnt rsp rdata         stray stall req rd            err
        run_op("alu",        1, 0, 0, 32'h0000_1234, 32'h0,        5'd5,  -1, 0, 32'h0,        0,  0,  0, 32'h0,        2'b00);
        run_op("alu_odd",    1, 0, 0, 32'h0000_1237, 32'h0,        5'd7,  -1, 0, 32'h0,        0,  0,  0, 32'h0,        2'b00);
        run_op("load_fast",  1, 1, 0, 32'h0000_0040, 32'h0,        5'd8,   0, 1, 32'hDEADBEEF, 0,  2,  1, 32'hDEADBEEF, 2'b00);
        run_op("store_slow", 0, 0, 1, 32'h0000_0080, 32'hA5A5A5A5, 5'd0,   3, 2, 32'h1111_2222, 0,  6,  4, 32'h0,        2'b00);
        run_op("load_mis",   1, 1, 0, 32'h0000_0042, 32'h0,        5'd9,  -1, 0, 32'h0,        0,  0,  0, 32'h0,        2'b01);
        run_op("store_mis",  0, 0, 1, 32'h0000_0081, 32'h5,        5'd0,  -1, 0, 32'h0,        0,  0,  0, 32'h0,        2'b01);
        run_op("load_mid",   1, 1, 0, 32'h0000_0100, 32'h0,        5'd10,  1, 3, 32'hCAFE_F00D, 0,  5,  2, 32'hCAFEF00D, 2'b00);
        run_op("to_rsp",     1, 1, 0, 32'h0000_0200, 32'h0,        5'd11,  0, 0, 32'h0BAD_0BAD, 0, 17,  1, 32'h0,        2'b10);
        run_op("late_rv",    1, 0, 0, 32'h0000_4444, 32'h0,        5'd12, -1, 0, 32'h0BAD_0BAD, 1,  0,  0, 32'h0,        2'b00);
        run_op("to_gnt",     1, 1, 0, 32'h0000_0300, 32'h0,        5'd13, -1, 0, 32'h0,        0, 17, 17, 32'h0,        2'b10);

        // Reset while waiting for a response.
        regWriteM = 1'b1; memToRegM = 1'b1; memWriteM = 1'b0;
        aluOutM = 32'h0000_0500; writeRegM = 5'd14;
        #1 dmem_gnt = 1'b1;
        @(posedge clk); #1 dmem_gnt = 1'b0;
        @(posedge clk); #1;
        check("rst_pre.stallM", 32'(stallM), 1);
        rst = 1'b0;
        #1;
        check_w_zero("rst_mid");
        @(posedge clk); #1;
        check_w_zero("rst_mid_hold");
        rst = 1'b1;
        run_op("post_rst_rv", 1, 0, 0, 32'h0000_6666, 32'h0, 5'd15, -1, 0, 32'h1234_5678, 1, 0, 0, 32'h0, 2'b00);
        run_op("post_rst_ld", 1, 1, 0, 32'h0000_0600, 32'h0, 5'd16, 0, 1, 32'h8765_4321, 0, 2, 1, 32'h87654321, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
